// File: rtl/misc_v_pkg.sv
// Shared definitions for the 16-bit MISC-V pipeline: datapath widths and
// the write-back source encoding used by the WB stage.
package misc_v_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/write_stage_wb_mux.sv
// Write-back source selector: picks the memory load data or the ALU result,
// full width, no extension or masking.
module wb_mux #(
  parameter int DATA_W = misc_v_pkg::DATA_W
) (
  input  logic              sel_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] mem_i,
  output logic [DATA_W-1:0] wb_data_o
);
  import misc_v_pkg::*;

  assign wb_data_o = (wb_src_e'(sel_i) == WB_SRC_MEM) ? mem_i : alu_i;

endmodule

// File: rtl/write_stage.sv
// MISC-V write-back stage: registers the selected write-back value, destination
// index and write enable. Optional r0 write suppression via WRITE_STAGE_R0_GUARD_EN.
module write_stage #(
  parameter int DATA_W     = misc_v_pkg::DATA_W,
  parameter int REG_ADDR_W = misc_v_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic                  RegStore,
  input  logic [DATA_W-1:0]     ALUResult,
  input  logic [DATA_W-1:0]     StoreMem,
  input  logic [REG_ADDR_W-1:0] rdWB,
  output logic [DATA_W-1:0]     loadData,
  output logic [REG_ADDR_W-1:0] loadAddr,
  output logic                  regWriteOut
);
  import misc_v_pkg::*;

  logic [DATA_W-1:0]     load_data_d, load_data_q;
  logic [REG_ADDR_W-1:0] load_addr_d, load_addr_q;
  logic                  reg_write_d, reg_write_q;

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .sel_i     (RegStore),
    .alu_i     (ALUResult),
    .mem_i     (StoreMem),
    .wb_data_o (load_data_d)
  );

  assign load_addr_d = rdWB;

`ifdef WRITE_STAGE_R0_GUARD_EN
  // r0 is hardwired zero: the data/address still flow, only the enable is dropped.
  assign reg_write_d = RegWrite & (rdWB != '0);
`else
  assign reg_write_d = RegWrite;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_data_q <= '0;
      load_addr_q <= '0;
      reg_write_q <= 1'b0;
    end else begin
      load_data_q <= load_data_d;
      load_addr_q <= load_addr_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign loadData    = load_data_q;
  assign loadAddr    = load_addr_q;
  assign regWriteOut = reg_write_q;

endmodule

// File: tb/tb_write_stage.sv
// Self-checking bench for write_stage: table vectors, random vectors through a
// scoreboard queue, plus hand-written async reset sequences.
module tb_write_stage;

`ifdef WRITE_STAGE_R0_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite, RegStore;
  logic [15:0] ALUResult, StoreMem;
  logic [2:0]  rdWB;
  logic [15:0] loadData;
  logic [2:0]  loadAddr;
  logic        regWriteOut;

  write_stage dut (
    .clk         (clk),
    .reset       (reset),
    .RegWrite    (RegWrite),
    .RegStore    (RegStore),
    .ALUResult   (ALUResult),
    .StoreMem    (StoreMem),
    .rdWB        (rdWB),
    .loadData    (loadData),
    .loadAddr    (loadAddr),
    .regWriteOut (regWriteOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        st;
    logic [15:0] alu;
    logic [15:0] mem;
    logic [2:0]  rd;
    logic [15:0] exp_data;
    logic [2:0]  exp_addr;
    logic        exp_we;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic [2:0]  addr;
    logic        we;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input string name, input logic we, input logic st,
                       input logic [15:0] alu, input logic [15:0] mem, input logic [2:0] rd,
                       input logic [15:0] ed, input logic [2:0] ea, input logic ew);
    exp_t e;
    RegWrite = we; RegStore = st; ALUResult = alu; StoreMem = mem; rdWB = rd;
    e.name = name; e.data = ed; e.addr = ea; e.we = ew;
    sb_q.push_back(e);
  endtask

  // One edge later the DUT must show the oldest pushed expectation.
  task automatic step_and_compare();
    exp_t e;
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: queue empty, got data %h", loadData);
    end else begin
      e = sb_q.pop_front();
      chk({e.name, ".data"}, loadData, e.data);
      chk({e.name, ".addr"}, {13'd0, loadAddr}, {13'd0, e.addr});
      chk({e.name, ".we"},   {15'd0, regWriteOut}, {15'd0, e.we});
      $display("txn %s: data=%h addr=%0d we=%0d", e.name, loadData, loadAddr, regWriteOut);
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{"alu_path",   1, 0, 16'hBEEF, 16'h1111, 3'd3, 16'hBEEF, 3'd3, 1'b1};
    tbl[1] = '{"mem_path",   1, 1, 16'h0F0F, 16'hA5A5, 3'd7, 16'hA5A5, 3'd7, 1'b1};
    tbl[2] = '{"no_write",   0, 0, 16'h0042, 16'h9999, 3'd2, 16'h0042, 3'd2, 1'b0};
    tbl[3] = '{"r0_guard",   1, 0, 16'hFFFF, 16'h0000, 3'd0, 16'hFFFF, 3'd0, !GUARD};
    tbl[4] = '{"mem_nowr",   0, 1, 16'h1357, 16'h2468, 3'd6, 16'h2468, 3'd6, 1'b0};
    tbl[5] = '{"b2b_a",      1, 0, 16'h0001, 16'h8000, 3'd4, 16'h0001, 3'd4, 1'b1};
    tbl[6] = '{"b2b_b",      1, 1, 16'h0001, 16'h8000, 3'd4, 16'h8000, 3'd4, 1'b1};
    tbl[7] = '{"r0_mem",     1, 1, 16'h0000, 16'hC3C3, 3'd0, 16'hC3C3, 3'd0, !GUARD};

    // Reset held with active inputs across several edges.
    reset = 1'b0;
    RegWrite = 1; RegStore = 0; ALUResult = 16'h1234; StoreMem = 16'h5678; rdWB = 3'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold.data", loadData, 16'h0000);
    chk("rst_hold.addr", {13'd0, loadAddr}, 16'h0000);
    chk("rst_hold.we",   {15'd0, regWriteOut}, 16'h0000);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].name, tbl[i].we, tbl[i].st, tbl[i].alu, tbl[i].mem, tbl[i].rd,
            tbl[i].exp_data, tbl[i].exp_addr, tbl[i].exp_we);
      step_and_compare();
    end

    // Async reset between edges, with a write already captured.
    drive("pre_rst", 1, 0, 16'h7777, 16'h0000, 3'd5, 16'h7777, 3'd5, 1'b1);
    step_and_compare();
    #2 reset = 1'b0;
    #1;
    chk("async_rst.data", loadData, 16'h0000);
    chk("async_rst.addr", {13'd0, loadAddr}, 16'h0000);
    chk("async_rst.we",   {15'd0, regWriteOut}, 16'h0000);
    RegWrite = 1; RegStore = 1; StoreMem = 16'hDEAD; rdWB = 3'd1;
    @(posedge clk); #1;
    chk("rst_held.data", loadData, 16'h0000);
    chk("rst_held.we",   {15'd0, regWriteOut}, 16'h0000);
    reset = 1'b1;
    drive("post_rst", 1, 1, 16'h0000, 16'hDEAD, 3'd1, 16'hDEAD, 3'd1, 1'b1);
    step_and_compare();

    // Random traffic with a bench-side model of the selector and guard.
    for (int i = 0; i < 16; i++) begin
      logic        we, st;
      logic [15:0] alu, mem;
      logic [2:0]  rd;
      we  = 1'($urandom_range(0, 1));
      st  = 1'($urandom_range(0, 1));
      alu = 16'($urandom);
      mem = 16'($urandom);
      rd  = 3'($urandom_range(0, 7));
      drive($sformatf("rnd%0d", i), we, st, alu, mem, rd,
            st ? mem : alu, rd, we & (!GUARD || rd != 3'd0));
      step_and_compare();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/write_stage.md
# write_stage

Write-back (WB) stage of the 16-bit MISC-V pipeline, sitting after the memory stage and feeding the register file write port. It selects the write-back value between the ALU result and the memory load data, and registers that value with the destination register address and write enable. The register file consumes these registered outputs on the following clock edge.

## Interface
Parameters:
- DATA_W, 16: width of the data path.
- REG_ADDR_W, 3: width of a register index (8 architectural registers).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low (reset = 0 asserts).
- RegWrite  input  1  the instruction in WB writes a register.
- RegStore  input  1  write-back source select: 1 = StoreMem (load data), 0 = ALUResult.
- ALUResult  input  16  ALU result from the previous stage.
- StoreMem  input  16  data read from data memory.
- rdWB  input  3  destination register index.
- loadData  output  16  registered write-back data to the register file.
- loadAddr  output  3  registered destination register index.
- regWriteOut  output  1  registered register-file write enable.

## Operation
- Combinational select: wb_data = RegStore ? StoreMem : ALUResult (full 16-bit, no extension or truncation).
- Rising edge of clk with reset = 1:
  - loadData <= wb_data
  - loadAddr <= rdWB
  - regWriteOut <= RegWrite
- Data and address are captured every cycle regardless of RegWrite. A capture with RegWrite = 0 is harmless because regWriteOut = 0 gates the write.
- RegStore is honoured even when RegWrite = 0; only the value captured in loadData is affected.
- X/undefined inputs are not cleaned or masked. The stage relies on upstream stages to present valid signals.

## Timing
- Latency: exactly 1 cycle, from inputs sampled at edge N to outputs valid after edge N.
- Reset assertion (reset falls) clears loadData = 16'h0000, loadAddr = 3'b000 and regWriteOut = 0 immediately, without waiting for clk.
- Reset mid-operation: any in-flight write is dropped. Outputs stay zero while reset = 0.
- After reset deasserts, the first capture happens on the next rising edge.
- No handshake and no stall input. Every edge advances the stage.
- Back-to-back writes to the same rdWB are passed through unchanged, one per cycle.

## Configuration
- Macro: WRITE_STAGE_R0_GUARD_EN.
- When defined:
  - regWriteOut <= RegWrite & (rdWB != 0), so writes to register 0 are suppressed.
  - loadData and loadAddr are still captured as normal.
- When undefined: regWriteOut <= RegWrite unconditionally, so register 0 is writable.

## Structure
- Shared package misc_v_pkg holds:
  - DATA_W = 16 and REG_ADDR_W = 3;
  - the write-back source encoding, WB_SRC_ALU = 1'b0 and WB_SRC_MEM = 1'b1.
- One natural sub-module, wb_mux: the combinational 2:1 selector of ALUResult and StoreMem.
- The top level holds the three output registers and the optional r0 guard.

## Test plan
- Reset: hold reset = 0 with active inputs (RegWrite = 1, ALUResult = 16'h1234, rdWB = 5) across edges -> loadData = 0, loadAddr = 0, regWriteOut = 0.
- ALU path: RegWrite = 1, RegStore = 0, ALUResult = 16'hBEEF, StoreMem = 16'h1111, rdWB = 3 -> after one edge, loadData = 16'hBEEF, loadAddr = 3, regWriteOut = 1.
- Memory path: RegStore = 1, StoreMem = 16'hA5A5, ALUResult = 16'h0F0F, rdWB = 7, RegWrite = 1 -> loadData = 16'hA5A5, loadAddr = 7, regWriteOut = 1.
- No write: RegWrite = 0, ALUResult = 16'h0042, rdWB = 2 -> regWriteOut = 0, loadData = 16'h0042, loadAddr = 2.
- Async reset mid-stream: after a write is captured, drive reset = 0 between edges -> all outputs go to 0 before the next edge. Release reset -> normal capture on the following edge.
- r0 guard: RegWrite = 1, rdWB = 0, ALUResult = 16'hFFFF -> regWriteOut = 0 with WRITE_STAGE_R0_GUARD_EN defined, 1 without. loadData = 16'hFFFF in both builds.
